// File: rtl/weight_packer.sv
// weight_packer: transmit side of the weight-buffer load interface.
// Accepts one filter row per handshake (up to MAX_FILTER weights, MSB-aligned)
// and emits the OUTPUT_WIDTH-bit word stream the weight buffer consumes.
// Full-width rows (S = MAX_FILTER) are packed as one contiguous MSB-first
// bitstream with the final word zero-padded; narrower rows take one word each.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, latches param_r/param_s in IDLE
//   param_r, param_s    filter height / width, legal range 1..MAX_FILTER
//   in_valid/in_ready   row handshake, in_row carries the row
//   out_valid/out_ready word handshake, out_data carries the word
//   out_last            marks the final word of the filter
//   busy                packer is not idle
//   done                one-cycle pulse after the last word handshake
//   cfg_err             one-cycle pulse when start carries illegal params
//
// state | meaning
// IDLE  | waiting for start
// PACK  | accepting rows and emitting full words
// FLUSH | all rows taken, emitting the zero-padded final partial word
module weight_packer #(
    parameter  int WEIGHT_WIDTH = 8,
    parameter  int MAX_FILTER   = 5,
    parameter  int OUTPUT_WIDTH = 32,
    localparam int ROW_WIDTH    = WEIGHT_WIDTH * MAX_FILTER
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              param_r,
    input  logic [3:0]              param_s,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROW_WIDTH-1:0]    in_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam int ACC_WIDTH = ROW_WIDTH + OUTPUT_WIDTH;
    localparam int CNT_W     = $clog2(ACC_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           rows_acc;
    logic [3:0]           r_lat;
    logic [3:0]           s_lat;

    logic [ACC_WIDTH-1:0]    row_ext;
    logic [ACC_WIDTH-1:0]    row_placed;
    logic [CNT_W-1:0]        row_bits;
    logic [OUTPUT_WIDTH-1:0] short_mask;
    int                      mask_sh;
    logic                    all_rows;
    logic                    params_ok;
    logic                    in_hs;
    logic                    out_hs;

    // Row left-justified in the accumulator width, then shifted down to sit
    // directly below the bits already held.
    always_comb begin
        row_ext    = '0;
        row_bits   = CNT_W'(OUTPUT_WIDTH);
        mask_sh    = OUTPUT_WIDTH - int'(s_lat) * WEIGHT_WIDTH;
        short_mask = {OUTPUT_WIDTH{1'b1}} << mask_sh;
        if (s_lat == 4'(MAX_FILTER)) begin
            row_ext[ACC_WIDTH-1 -: ROW_WIDTH] = in_row;
            row_bits = CNT_W'(ROW_WIDTH);
        end else begin
            row_ext[ACC_WIDTH-1 -: OUTPUT_WIDTH] = in_row[ROW_WIDTH-1 -: OUTPUT_WIDTH] & short_mask;
        end
        row_placed = row_ext >> cnt;
    end

    assign all_rows  = (rows_acc == r_lat);
    assign params_ok = (param_r >= 4'd1) && (param_r <= 4'(MAX_FILTER)) &&
                       (param_s >= 4'd1) && (param_s <= 4'(MAX_FILTER));

    // Handshake outputs depend on registered state only.
    assign in_ready  = (state == PACK) && (rows_acc < r_lat) && (cnt < CNT_W'(OUTPUT_WIDTH));
    assign out_valid = (cnt >= CNT_W'(OUTPUT_WIDTH)) || (state == FLUSH);
    // In PACK the last word is the one that drains the accumulator exactly.
    assign out_last  = (state == FLUSH) ||
                       ((state == PACK) && all_rows && (cnt == CNT_W'(OUTPUT_WIDTH)));
    assign out_data  = out_valid ? acc[ACC_WIDTH-1 -: OUTPUT_WIDTH] : '0;
    assign busy      = (state != IDLE);

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            rows_acc <= '0;
            r_lat    <= '0;
            s_lat    <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (params_ok) begin
                            r_lat    <= param_r;
                            s_lat    <= param_s;
                            acc      <= '0;
                            cnt      <= '0;
                            rows_acc <= '0;
                            state    <= PACK;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                PACK: begin
                    if (in_hs) begin
                        acc      <= acc | row_placed;
                        cnt      <= cnt + row_bits;
                        rows_acc <= rows_acc + 4'd1;
                    end else if (out_hs) begin
                        acc <= acc << OUTPUT_WIDTH;
                        cnt <= cnt - CNT_W'(OUTPUT_WIDTH);
                        if (out_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else if (all_rows && (cnt != '0) && (cnt < CNT_W'(OUTPUT_WIDTH))) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Bits below cnt are already zero, so the top word is padded.
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_packer.sv
module tb_weight_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  param_r;
    logic [3:0]  param_s;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_row;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    weight_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .param_r  (param_r),
        .param_s  (param_s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_row   (in_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        int               r;
        int               s;
        int               nw;
        logic [4:0][39:0] rows;
        logic [6:0][31:0] w;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_table(input int idx);
        exp_t e;
        for (int k = 0; k < tbl[idx].nw; k++) begin
            e.d = tbl[idx].w[k];
            e.l = (k == tbl[idx].nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Bit-serial reference: rows become a flat MSB-first bitstream, then cut into words.
    function automatic void push_model(input int r, input int s, input logic [4:0][39:0] rws);
        bit          q[$];
        logic [31:0] w;
        exp_t        e;
        for (int j = 0; j < r; j++) begin
            if (s == 5) begin
                for (int b = 39; b >= 0; b--) q.push_back(rws[j][b]);
            end else begin
                for (int b = 39; b >= 8; b--) q.push_back((b >= 40 - s * 8) ? rws[j][b] : 1'b0);
            end
        end
        while (q.size() > 0) begin
            for (int b = 31; b >= 0; b--) w[b] = (q.size() > 0) ? q.pop_front() : 1'b0;
            e.d = w;
            e.l = (q.size() == 0);
            exp_q.push_back(e);
        end
    endfunction

    task automatic run_filter(input int r, input int s, input logic [4:0][39:0] rws,
                              input bit rnd, input bit inject, input string tag);
        int          sent = 0;
        int          words = 0;
        int          cyc = 0;
        int          nexp;
        bit          got_last = 1'b0;
        bit          stall = 1'b0;
        bit          cerr = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        exp_t        e;
        nexp = exp_q.size();
        @(negedge clk);
        start = 1'b1; param_r = 4'(r); param_s = 4'(s);
        @(negedge clk);
        start = 1'b0;
        while (!got_last && cyc < 1000) begin
            in_valid  = (sent < r) && (rnd ? ($urandom_range(1, 0) == 1) : 1'b1);
            in_row    = rws[(sent < 5) ? sent : 0];
            out_ready = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (inject) begin
                start   = (cyc == 3) || (cyc == 6);
                param_r = (cyc == 3) ? 4'd0 : 4'd4;
                param_s = (cyc == 3) ? 4'd6 : 4'd4;
            end
            if (cfg_err) cerr = 1'b1;
            if (stall) begin
                check({tag, " stall_data"}, 64'(out_data), 64'(pd));
                check({tag, " stall_last"}, 64'(out_last), 64'(pl));
            end
            if (!out_valid) check({tag, " idle_data_zero"}, 64'(out_data), 64'd0);
            if (rnd) check({tag, " ready_while_full"}, 64'(in_ready && out_valid), 64'd0);
            if (in_valid && in_ready) sent++;
            stall = out_valid && !out_ready;
            pd    = out_data;
            pl    = out_last;
            if (out_valid && out_ready) begin
                words++;
                if (exp_q.size() == 0) begin
                    check({tag, " extra_word"}, 64'(out_data), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " data"}, 64'(out_data), 64'(e.d));
                    check({tag, " last"}, 64'(out_last), 64'(e.l));
                end
                got_last = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, " finished"}, 64'(got_last), 64'd1);
        check({tag, " word_count"}, 64'(words), 64'(nexp));
        check({tag, " done_pulse"}, 64'(done), 64'd1);
        check({tag, " idle_after"}, 64'(busy), 64'd0);
        if (inject) check({tag, " no_cfg_err_busy"}, 64'(cerr), 64'd0);
        @(negedge clk);
        check({tag, " done_single"}, 64'(done), 64'd0);
    endtask

    task automatic cfg_bad(input int r, input int s, input string tag);
        @(negedge clk);
        start = 1'b1; param_r = 4'(r); param_s = 4'(s);
        @(negedge clk);
        start = 1'b0;
        check({tag, " cfg_err"}, 64'(cfg_err), 64'd1);
        check({tag, " busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, " cfg_err_single"}, 64'(cfg_err), 64'd0);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][39:0] rr;
        int   words;
        int   sent;
        exp_t e;

        tbl[0].r = 5; tbl[0].s = 5; tbl[0].nw = 7;
        tbl[0].rows = '0; tbl[0].w = '0;
        tbl[0].rows[0] = 40'h1111111111; tbl[0].rows[1] = 40'h2222222222;
        tbl[0].rows[2] = 40'h3333333333; tbl[0].rows[3] = 40'h4444444444;
        tbl[0].rows[4] = 40'h5555555555;
        tbl[0].w[0] = 32'h11111111; tbl[0].w[1] = 32'h11222222; tbl[0].w[2] = 32'h22223333;
        tbl[0].w[3] = 32'h33333344; tbl[0].w[4] = 32'h44444444; tbl[0].w[5] = 32'h55555555;
        tbl[0].w[6] = 32'h55000000;

        tbl[1].r = 2; tbl[1].s = 5; tbl[1].nw = 3;
        tbl[1].rows = '0; tbl[1].w = '0;
        tbl[1].rows[0] = 40'h0102030405; tbl[1].rows[1] = 40'h060708090A;
        tbl[1].w[0] = 32'h01020304; tbl[1].w[1] = 32'h05060708; tbl[1].w[2] = 32'h090A0000;

        tbl[2].r = 3; tbl[2].s = 3; tbl[2].nw = 3;
        tbl[2].rows = '0; tbl[2].w = '0;
        tbl[2].rows[0] = 40'hAABBCC1234; tbl[2].rows[1] = 40'hDDEEFF5678;
        tbl[2].rows[2] = 40'h1122339ABC;
        tbl[2].w[0] = 32'hAABBCC00; tbl[2].w[1] = 32'hDDEEFF00; tbl[2].w[2] = 32'h11223300;

        tbl[3].r = 1; tbl[3].s = 1; tbl[3].nw = 1;
        tbl[3].rows = '0; tbl[3].w = '0;
        tbl[3].rows[0] = 40'hAB12345678;
        tbl[3].w[0] = 32'hAB000000;

        tbl[4].r = 4; tbl[4].s = 4; tbl[4].nw = 4;
        tbl[4].rows = '0; tbl[4].w = '0;
        tbl[4].rows[0] = 40'h0102030499; tbl[4].rows[1] = 40'h05060708AA;
        tbl[4].rows[2] = 40'h090A0B0CBB; tbl[4].rows[3] = 40'h0D0E0F10CC;
        tbl[4].w[0] = 32'h01020304; tbl[4].w[1] = 32'h05060708;
        tbl[4].w[2] = 32'h090A0B0C; tbl[4].w[3] = 32'h0D0E0F10;

        tbl[5].r = 2; tbl[5].s = 2; tbl[5].nw = 2;
        tbl[5].rows = '0; tbl[5].w = '0;
        tbl[5].rows[0] = 40'hDEADBEEF00; tbl[5].rows[1] = 40'hCAFEF00D11;
        tbl[5].w[0] = 32'hDEAD0000; tbl[5].w[1] = 32'hCAFE0000;

        rst_n = 1'b0; start = 1'b0; param_r = '0; param_s = '0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset outputs", 64'({in_ready, out_valid, out_last, busy, done, cfg_err}), 64'd0);
        check("reset data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            push_table(i);
            run_filter(tbl[i].r, tbl[i].s, tbl[i].rows, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        push_table(0);
        run_filter(5, 5, tbl[0].rows, 1'b1, 1'b0, "rnd 5x5");
        push_table(3);
        run_filter(1, 1, tbl[3].rows, 1'b1, 1'b0, "rnd 1x1");
        push_table(1);
        run_filter(2, 5, tbl[1].rows, 1'b0, 1'b1, "start while busy");

        for (int j = 0; j < 5; j++) rr[j] = {$urandom(), 8'($urandom())};
        push_model(5, 5, rr);
        run_filter(5, 5, rr, 1'b1, 1'b0, "model 5x5");
        push_model(3, 2, rr);
        run_filter(3, 2, rr, 1'b1, 1'b0, "model 3x2");

        cfg_bad(0, 3, "R=0");
        cfg_bad(3, 6, "S=6");

        // Reset in the middle of a 5x5 filter after three words.
        push_table(0);
        @(negedge clk);
        start = 1'b1; param_r = 4'd5; param_s = 4'd5;
        @(negedge clk);
        start = 1'b0;
        words = 0;
        sent  = 0;
        for (int cyc = 0; cyc < 200 && words < 3; cyc++) begin
            in_valid  = (sent < 5);
            in_row    = tbl[0].rows[(sent < 5) ? sent : 0];
            out_ready = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("pre-reset data", 64'(out_data), 64'(e.d));
                words++;
            end
            @(negedge clk);
        end
        check("pre-reset words", 64'(words), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid reset outputs", 64'({in_ready, out_valid, out_last, busy, done, cfg_err}), 64'd0);
        check("mid reset data", 64'(out_data), 64'd0);
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_table(4);
        run_filter(4, 4, tbl[4].rows, 1'b0, 1'b0, "after reset 4x4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_packer.md
Name: weight_packer

Overview:
- Transmit side of the weight-buffer load interface. It accepts one filter row per handshake: up to 5 weights of 8 bits, MSB-aligned in 40 bits.
- It emits the 32-bit word stream that the weight buffer consumes on WR_DATA/WR_VALID/WR_EN.
- For S=5, rows are packed as one contiguous MSB-first bitstream and the final word is zero-padded. For S<=4, each row is sent as exactly one word.
- It sits between the weight fetch logic and the weight buffer.

Parameters:
- WEIGHT_WIDTH, 8, bits per weight.
- MAX_FILTER, 5, maximum value of R and S.
- OUTPUT_WIDTH, 32, output word width.
- ROW_WIDTH, WEIGHT_WIDTH*MAX_FILTER (40), input row width. Derived; do not override.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; latches PARAM_R/PARAM_S and begins a filter.
- PARAM_R  in  4  filter height (rows to accept), 1..5.
- PARAM_S  in  4  filter width (weights per row), 1..5.
- IN_VALID  in  1  IN_ROW is valid.
- IN_READY  out  1  packer accepts a row this cycle.
- IN_ROW  in  ROW_WIDTH  row data; weight 0 at [39:32]; bits below S*8 are don't-care.
- OUT_VALID  out  1  OUT_DATA valid; drives buffer WR_VALID.
- OUT_READY  in  1  sink accepts; driven from buffer WR_EN.
- OUT_DATA  out  OUTPUT_WIDTH  packed word.
- OUT_LAST  out  1  high with the final word of the filter.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse after the last word handshake.
- CFG_ERR  out  1  one-cycle pulse when START carries illegal params.

Behaviour:
- Reset: asynchronous, takes effect at any time including mid-filter.
  - State=IDLE; accumulator, bit count, row count, latched params cleared.
  - IN_READY, OUT_VALID, OUT_LAST, BUSY, DONE, CFG_ERR all 0; OUT_DATA=0.
- States: IDLE, PACK, FLUSH.
- IDLE:
  - START with R and S both in 1..5: latch params, go to PACK next cycle.
  - START with R or S equal to 0 or >5: stay IDLE, CFG_ERR=1 for one cycle.
- START outside IDLE is ignored; no CFG_ERR is raised.
- Row width W: 40 when S=5, else 32. For S<=4 only IN_ROW[39:8] is used and the low (32-S*8) bits of the word are zeroed.
- Accumulator: 72-bit, left-justified, cnt = valid bits (0..71).
  - Accepted row: its W bits are written starting at bit 71-cnt; cnt += W.
  - Output handshake: OUT_DATA = acc[71:40]; acc shifts left 32; cnt -= 32.
- IN_READY = (state==PACK) && (rows_accepted < R) && (cnt < 32). It is a registered-state function only, with no combinational path from OUT_READY.
- OUT_VALID = (cnt >= 32) || (state==FLUSH). It is registered, so the first word appears the cycle after the row handshake.
- Input acceptance and output emission are mutually exclusive by construction: input needs cnt<32, output needs cnt>=32 or FLUSH.
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST hold stable.
- Once all R rows are accepted:
  - cnt in 1..31: go to FLUSH and emit acc[71:40], zero-padded, with OUT_LAST=1.
  - cnt = 0 after the last handshake: that word carries OUT_LAST=1.
- On the OUT_LAST handshake: state -> IDLE at that edge, and DONE=1 in the following cycle.
- Word count per filter: ceil(R*40/32) for S=5, R for S<=4. For example, 5x5 gives 7 words and 2x5 gives 3.
- OUT_DATA is 0 whenever OUT_VALID=0.

Test Plan:
- 5x5, rows 0x1111111111, 0x2222222222, 0x3333333333, 0x4444444444, 0x5555555555, OUT_READY=1 -> words 0x11111111, 0x11222222, 0x22223333, 0x33333344, 0x44444444, 0x55555555, then 0x55000000 with OUT_LAST; DONE pulses once.
- 2x5, rows 0x0102030405, 0x060708090A -> 0x01020304, 0x05060708, then 0x090A0000 with LAST (FLUSH path).
- 3x3, rows 0xAABBCCxxxx, 0xDDEEFFxxxx, 0x112233xxxx -> 0xAABBCC00, 0xDDEEFF00, then 0x11223300 with LAST; 3 words total.
- Random OUT_READY/IN_VALID (50%) on 5x5 and 1x1 -> identical word sequence; OUT_DATA stable while stalled; IN_READY never high when cnt>=32.
- START with R=0, and separately with S=6 -> CFG_ERR single pulse, BUSY stays 0; START while BUSY ignored.
- Assert RESETN=0 after 3 words of a 5x5 -> all outputs 0 immediately; a new 4x4 filter then produces exactly 4 words.
